// File: rtl/grp_buf_writer.sv
// Group buffer writer: collects received words into one of two ping-pong
// buffers. The frame former's buffer select (bufSwitch) hands a buffer over;
// the writer then fills the other one, dropping words once it is full and
// counting groups that were cut short by an early switch.
module grp_buf_writer #(
  parameter int GRP_WORDS = 1024,
  parameter int ADR_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      word,
  input  logic             ready,
  input  logic             bufSwitch,
  output logic [11:0]      wrData,
  output logic [ADR_W-1:0] wrAdr,
  output logic             m0_WE,
  output logic             m1_WE,
  output logic             wrBuf,
  output logic [7:0]       ovfCnt,
  output logic [7:0]       udrCnt
);

  typedef enum logic [1:0] {
    WAIT_SYNC,
    FILL,
    FULL
  } state_t;

  localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(GRP_WORDS - 1);

  state_t           state, state_nxt;
  logic [ADR_W-1:0] ptr, ptr_nxt;
  logic             sync_q1, sync_q2, sync_prev;
  logic             switch_ev;
  logic             buf_nxt;
  logic             we0_nxt, we1_nxt;
  logic [11:0]      data_nxt;
  logic [ADR_W-1:0] adr_nxt;
  logic             ovf_inc, udr_inc;
  logic             unused_word_hi;

  // The upper nibble of the received word carries nothing for the buffer.
  always_comb unused_word_hi = ^word[15:12];

  // Two-flop synchronizer for bufSwitch plus a history flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_q1   <= bufSwitch;
      sync_q2   <= sync_q1;
      sync_prev <= sync_q2;
    end
  end

  // State and pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WAIT_SYNC;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next state and write decode. A switch is applied before the ready word
  // is classified, so a coincident word lands at address 0 of the new buffer.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    buf_nxt   = wrBuf;
    we0_nxt   = 1'b0;
    we1_nxt   = 1'b0;
    data_nxt  = wrData;
    adr_nxt   = wrAdr;
    ovf_inc   = 1'b0;
    udr_inc   = 1'b0;
    switch_ev = sync_q2 ^ sync_prev;

    if (switch_ev) begin
      buf_nxt   = ~sync_q2;
      udr_inc   = (state == FILL) && (ptr != '0);
      state_nxt = FILL;
      ptr_nxt   = '0;
    end

    if (ready) begin
      case (state_nxt)
        FILL: begin
          data_nxt = word[11:0];
          adr_nxt  = ptr_nxt;
          we0_nxt  = ~buf_nxt;
          we1_nxt  = buf_nxt;
          if (ptr_nxt == LAST_ADR) begin
            state_nxt = FULL;
            ptr_nxt   = '0;
          end else begin
            ptr_nxt = ptr_nxt + 1'b1;
          end
        end
        FULL:    ovf_inc = 1'b1;
        default: ;
      endcase
    end
  end

  // Registered outputs and saturating event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrData <= '0;
      wrAdr  <= '0;
      m0_WE  <= 1'b0;
      m1_WE  <= 1'b0;
      wrBuf  <= 1'b0;
      ovfCnt <= '0;
      udrCnt <= '0;
    end else begin
      wrData <= data_nxt;
      wrAdr  <= adr_nxt;
      m0_WE  <= we0_nxt;
      m1_WE  <= we1_nxt;
      wrBuf  <= buf_nxt;
      if (ovf_inc && (ovfCnt != '1)) ovfCnt <= ovfCnt + 8'd1;
      if (udr_inc && (udrCnt != '1)) udrCnt <= udrCnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_grp_buf_writer.sv
// Scoreboard bench for grp_buf_writer: a transaction-level model predicts
// each buffer write and the counters; a negedge monitor compares them.
module tb_grp_buf_writer;

  localparam int GW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   word = '0;
  logic          ready = 1'b0;
  logic          bufSwitch = 1'b0;
  logic [11:0]   wrData;
  logic [AW-1:0] wrAdr;
  logic          m0_WE, m1_WE, wrBuf;
  logic [7:0]    ovfCnt, udrCnt;

  grp_buf_writer #(.GRP_WORDS(GW), .ADR_W(AW)) dut (
    .clk(clk), .reset(reset), .word(word), .ready(ready),
    .bufSwitch(bufSwitch), .wrData(wrData), .wrAdr(wrAdr),
    .m0_WE(m0_WE), .m1_WE(m1_WE), .wrBuf(wrBuf),
    .ovfCnt(ovfCnt), .udrCnt(udrCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          b;
    logic [AW-1:0] adr;
    logic [11:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = waiting for first switch, 1 = filling, 2 = full.
  int m_mode  = 0;
  int m_count = 0;
  bit m_own   = 0;
  int m_ovf   = 0;
  int m_udr   = 0;
  bit past [0:2] = '{0, 0, 0};  // bufSwitch as sampled 1, 2, 3 edges ago

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_count = 0; m_own = 0; m_ovf = 0; m_udr = 0;
      past = '{0, 0, 0};
      exp_q.delete();
    end else begin
      bit ev;
      bit nb;
      wr_t w;
      // The synchronized value seen now is the input sampled two edges ago.
      ev = (past[1] != past[2]);
      nb = !past[1];
      past[2] = past[1];
      past[1] = past[0];
      past[0] = bufSwitch;
      if (ev) begin
        if (m_mode == 1 && m_count != 0 && m_udr < 255) m_udr++;
        m_mode = 1; m_count = 0; m_own = nb;
      end
      if (ready) begin
        if (m_mode == 1) begin
          w.b = m_own; w.adr = AW'(m_count); w.data = word[11:0];
          exp_q.push_back(w);
          m_count++;
          if (m_count == GW) begin m_mode = 2; m_count = 0; end
        end else if (m_mode == 2) begin
          if (m_ovf < 255) m_ovf++;
        end
      end
    end
  end

  // Monitor: compare every presented write and the status outputs.
  always @(negedge clk) begin
    if (reset) begin
      check("we_exclusive", {31'd0, m0_WE & m1_WE}, 0);
      if (m0_WE || m1_WE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_buf_sel", {31'd0, m1_WE}, {31'd0, e.b});
          check("wr_adr", {29'd0, wrAdr}, {29'd0, e.adr});
          check("wr_data", {20'd0, wrData}, {20'd0, e.data});
        end
      end
      check("wrBuf", {31'd0, wrBuf}, {31'd0, m_own});
      check("ovfCnt", {24'd0, ovfCnt}, m_ovf);
      check("udrCnt", {24'd0, udrCnt}, m_udr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [15:0] w);
    ready = 1'b1;
    word  = w;
    tick();
    ready = 1'b0;
  endtask

  task automatic toggle();
    bufSwitch = ~bufSwitch;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wrData"}, {20'd0, wrData}, 0);
    check({tag, "_wrAdr"},  {29'd0, wrAdr}, 0);
    check({tag, "_we"},     {30'd0, m0_WE, m1_WE}, 0);
    check({tag, "_wrBuf"},  {31'd0, wrBuf}, 0);
    check({tag, "_ovf"},    {24'd0, ovfCnt}, 0);
    check({tag, "_udr"},    {24'd0, udrCnt}, 0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // Words before the first switch are discarded.
    repeat (5) send(16'($urandom));
    toggle();
    idle(3);
    check("sync_wrBuf", {31'd0, wrBuf}, 0);

    // First writes into buffer 0.
    send(16'hA123);
    check("first_we0", {30'd0, m0_WE, m1_WE}, 2);
    check("first_data", {20'd0, wrData}, 12'h123);
    check("first_adr", {29'd0, wrAdr}, 0);
    send(16'h0FFF);
    check("second_adr", {29'd0, wrAdr}, 1);

    // Fill the group, then overflow by two.
    repeat (GW - 2 + 2) send(16'($urandom));
    check("ovf_two", {24'd0, ovfCnt}, 2);

    // Switch out of FULL: next write to buffer 1 address 0.
    toggle();
    idle(3);
    send(16'h1234);
    check("after_full_we1", {30'd0, m0_WE, m1_WE}, 1);
    check("after_full_adr", {29'd0, wrAdr}, 0);

    // Short group: two words written, then switch.
    send(16'h5555);
    toggle();
    idle(3);
    check("udr_one", {24'd0, udrCnt}, 1);
    send(16'h6666);
    check("short_we0", {30'd0, m0_WE, m1_WE}, 2);
    check("short_adr", {29'd0, wrAdr}, 0);

    // Switch event coinciding with a ready word.
    bufSwitch = ~bufSwitch;
    tick();
    tick();
    send(16'h7ABC);
    check("coin_we1", {30'd0, m0_WE, m1_WE}, 1);
    check("coin_adr", {29'd0, wrAdr}, 0);
    check("coin_data", {20'd0, wrData}, 12'hABC);
    send(16'h8DEF);
    check("coin_next_adr", {29'd0, wrAdr}, 1);

    // Reset mid-group at pointer 7.
    repeat (5) send(16'($urandom));
    reset = 1'b0;
    #1 check_all_zero("midreset");
    tick();
    reset = 1'b1;
    repeat (4) send(16'($urandom));
    check("post_reset_no_we", {30'd0, m0_WE, m1_WE}, 0);
    toggle();
    idle(3);
    send(16'h0042);
    check("post_reset_adr", {29'd0, wrAdr}, 0);

    // Random traffic with occasional switches.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) bufSwitch = ~bufSwitch;
      ready = ($urandom_range(0, 99) < 60);
      word  = 16'($urandom);
      tick();
      ready = 1'b0;
    end

    // Overflow counter saturation.
    toggle();
    idle(3);
    repeat (300) send(16'($urandom));
    check("ovf_sat", {24'd0, ovfCnt}, 255);

    // Underflow counter saturation.
    repeat (260) begin
      send(16'($urandom));
      toggle();
      idle(3);
    end
    check("udr_sat", {24'd0, udrCnt}, 255);

    idle(3);
    check("pending_writes", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grp_buf_writer.md
GRP_BUF_WRITER -- requirements
Module: grp_buf_writer

Interface
REQ-001 The block SHALL have parameter GRP_WORDS, default 1024, meaning words per group buffer; legal range 2..1024.
REQ-002 The block SHALL have parameter ADR_W, default 10, meaning buffer address width.
REQ-003 The block SHALL have port clk  input  1  the single system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port reset  input  1  the reset; asynchronous, active-low.
REQ-005 The block SHALL have port word  input  16  the received word from the receiver stage.
REQ-006 The block SHALL have port ready  input  1  word-valid strobe, one clk wide.
REQ-007 The block SHALL have port bufSwitch  input  1  the frame former's current read-buffer select; it is asynchronous to clk.
REQ-008 The block SHALL have port wrData  output  12  the buffer write data.
REQ-009 The block SHALL have port wrAdr  output  ADR_W  the buffer write address.
REQ-010 The block SHALL have port m0_WE  output  1  write enable for buffer 0.
REQ-011 The block SHALL have port m1_WE  output  1  write enable for buffer 1.
REQ-012 The block SHALL have port wrBuf  output  1  the buffer currently owned by the writer.
REQ-013 The block SHALL have port ovfCnt  output  8  the count of dropped words; saturating.
REQ-014 The block SHALL have port udrCnt  output  8  the count of short groups; saturating.

Function
REQ-015 bufSwitch SHALL pass through a 2-flop synchronizer; a switch event is any change of the synchronized value.
REQ-016 On a switch event, wrBuf SHALL become the inverse of the new synchronized bufSwitch on the next clk.
REQ-017 The FSM SHALL have three states: WAIT_SYNC (the state after reset), FILL and FULL.
REQ-018 In WAIT_SYNC, ready words SHALL be discarded without counting and with no write enables.
REQ-019 A switch event in WAIT_SYNC SHALL cause a transition to FILL with the write pointer at 0.
REQ-020 In FILL, a ready word SHALL produce exactly one write one clk later, with the following outputs:
- wrData equal to word[11:0];
- wrAdr equal to the pointer;
- the enable m0_WE or m1_WE selected by wrBuf, asserted for one clk.
REQ-021 After each write the pointer SHALL increment; the write at pointer GRP_WORDS-1 SHALL cause a transition to FULL.
REQ-022 word[15:12] SHALL be ignored by the block.
REQ-023 In FULL, each ready word SHALL be dropped, and ovfCnt SHALL increment, saturating at 255.
REQ-024 A switch event in FULL SHALL cause a transition to FILL with the pointer at 0 in the new buffer.
REQ-025 A switch event in FILL with pointer not equal to 0 SHALL increment udrCnt (saturating at 255) and restart at pointer 0 in the new buffer, with no padding written.
REQ-026 A switch event in FILL with pointer equal to 0 SHALL only change the buffer and SHALL NOT increment udrCnt.
REQ-027 When ready and a switch event occur in the same clk, the switch SHALL take effect first: the word is written to address 0 of the new buffer, and the pointer becomes 1.
REQ-028 When ready and the transition to FULL coincide, the completing write SHALL occur; the next ready word SHALL be dropped.
REQ-029 m0_WE and m1_WE SHALL never be high in the same clk.
REQ-030 Each output SHALL be driven directly from a register.

Reset
REQ-031 While reset is low, the block SHALL asynchronously force the following:
- state to WAIT_SYNC;
- pointer, wrAdr, wrData, ovfCnt and udrCnt to 0;
- m0_WE and m1_WE to 0;
- wrBuf to 0;
- the synchronizer flops to 0.
REQ-032 Reset asserted mid-group SHALL abandon the group; after release the block SHALL discard words until a switch event.
REQ-033 Release of reset SHALL cause no write strobe.

Verification
REQ-034 After reset, send 5 ready words and then toggle bufSwitch 0->1 -> no write enables for the 5 words; within 3 clk of the toggle wrBuf=0 and the state is FILL.
REQ-035 In FILL with wrBuf=0, send word 16'hA123 -> on the next clk m0_WE=1, wrData=12'h123, wrAdr=0; then send 16'h0FFF -> wrAdr=1.
REQ-036 With GRP_WORDS=4, send 6 words -> 4 writes at addresses 0..3 and ovfCnt=2; then toggle bufSwitch -> FILL in the other buffer, and the next write goes to address 0.
REQ-037 With GRP_WORDS=4, write 2 words and then toggle bufSwitch -> udrCnt=1, and the next write uses the new enable at address 0.
REQ-038 Make the synchronized switch event coincide with ready -> the word is written at address 0 of the new buffer, and the following word is written at address 1.
REQ-039 Pull reset low mid-FILL at pointer 7 -> all outputs are 0 immediately; after release, ready words produce no writes until the next bufSwitch toggle.
